// File: rtl/round_key_sequencer.sv
// Steps the AES-128 key schedule: fetches each round key from SRAM and presents it on a valid/ready port.
// Build option ADDROUNDKEY_EN: key_out = state_in ^ round key instead of the bare round key.
//
// state    | meaning
// IDLE     | waiting for start
// READ0    | SRAM read of the cipher key (round 0)
// CAPT0    | capture round 0 key from SRAM read data
// PRESENT  | key_out valid, waiting for key_out_ready
// KICK     | one-cycle enable to the key expander
// WAIT_EXP | waiting for expansion_done (expander owns SRAM)
// HOLD     | drain cycles after expansion_done
// READK    | SRAM read of the freshly expanded round key
// CAPTK    | capture round key from SRAM read data
// DONE     | one-cycle schedule_done pulse
module round_key_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned HOLDOFF    = 5,
  parameter logic [15:0] KEY0_ADDR  = 16'd0,
  parameter logic [15:0] KEYN_ADDR  = 16'd16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic         expansion_done,
  input  logic [127:0] sram_read_value,
  input  logic         key_out_ready,
  output logic         key_exp_enable,
  output logic [3:0]   round_num,
  output logic         sram_read,
  output logic [15:0]  sram_addr,
  output logic [127:0] key_out,
  output logic         key_out_valid,
  output logic         busy,
  output logic         schedule_done
);

  typedef enum logic [3:0] {
    IDLE, READ0, CAPT0, PRESENT, KICK, WAIT_EXP, HOLD, READK, CAPTK, DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLDOFF);

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_key,   w_key_nxt;
  logic [7:0]   r_hold,  w_hold_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_round <= 4'd0;
      r_key   <= 128'd0;
      r_hold  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_key   <= w_key_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

`ifndef ADDROUNDKEY_EN
  logic w_unused_state_in;
  assign w_unused_state_in = ^state_in;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_round_nxt    = r_round;
    w_key_nxt      = r_key;
    w_hold_nxt     = r_hold;
    key_exp_enable = 1'b0;
    sram_read      = 1'b0;
    sram_addr      = 16'd0;
    key_out        = 128'd0;
    key_out_valid  = 1'b0;
    schedule_done  = 1'b0;
    busy           = (r_state != IDLE);
    round_num      = r_round;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = READ0;
          w_round_nxt = 4'd0;
        end
      end
      READ0: begin
        sram_read   = 1'b1;
        sram_addr   = KEY0_ADDR;
        w_state_nxt = CAPT0;
      end
      CAPT0, CAPTK: begin
        w_key_nxt   = sram_read_value;
        w_state_nxt = PRESENT;
      end
      PRESENT: begin
        key_out_valid = 1'b1;
`ifdef ADDROUNDKEY_EN
        key_out = state_in ^ r_key;
`else
        key_out = r_key;
`endif
        if (key_out_ready) begin
          if (r_round == LAST_ROUND) begin
            w_state_nxt = DONE;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_state_nxt = KICK;
          end
        end
      end
      KICK: begin
        key_exp_enable = 1'b1;
        w_state_nxt    = WAIT_EXP;
      end
      WAIT_EXP: begin
        if (expansion_done) begin
          if (HOLD_INIT == 8'd0) begin
            w_state_nxt = READK;
          end else begin
            w_hold_nxt  = HOLD_INIT;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // leave on the cycle the counter reaches its terminal count
        w_hold_nxt = r_hold - 8'd1;
        if (r_hold <= 8'd1) w_state_nxt = READK;
      end
      READK: begin
        sram_read   = 1'b1;
        sram_addr   = KEYN_ADDR;
        w_state_nxt = CAPTK;
      end
      DONE: begin
        schedule_done = 1'b1;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: directed FIPS-197 schedule from a vector table, reset corner,
// then randomized schedules with noise inputs checked against a cycle-timing reference model.
module tb_round_key_sequencer;

  localparam int          NR   = 10;
  localparam int          HOLD = 5;
  localparam logic [15:0] A0   = 16'd0;
  localparam logic [15:0] AN   = 16'd16;

  logic         clk = 1'b0;
  logic         n_rst, start, expansion_done, key_out_ready;
  logic [127:0] state_in, sram_read_value;
  logic         key_exp_enable, sram_read, key_out_valid, busy, schedule_done;
  logic [3:0]   round_num;
  logic [15:0]  sram_addr;
  logic [127:0] key_out;

  round_key_sequencer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .state_in(state_in),
    .expansion_done(expansion_done), .sram_read_value(sram_read_value),
    .key_out_ready(key_out_ready), .key_exp_enable(key_exp_enable),
    .round_num(round_num), .sram_read(sram_read), .sram_addr(sram_addr),
    .key_out(key_out), .key_out_valid(key_out_valid), .busy(busy),
    .schedule_done(schedule_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_en, n_sd;

  typedef struct {
    logic [127:0] key;
    int unsigned  dly;
    int unsigned  stall;
    logic [3:0]   exp_round;
  } vec_t;
  vec_t tbl[11];

  logic [127:0] s_key[11];
  int unsigned  s_dly[11];
  int unsigned  s_stl[11];
  logic [3:0]   s_rnd[11];

  // SRAM model: addr 0 holds the cipher key, addr 16 the latest expanded key
  logic [127:0] mem_key0, mem_keyn;
  always_ff @(posedge clk) begin
    if (sram_read)
      sram_read_value <= (sram_addr == A0) ? mem_key0 : (sram_addr == AN) ? mem_keyn : 128'd0;
    else
      sram_read_value <= {$urandom, $urandom, $urandom, $urandom};
  end

  function automatic logic [127:0] exp_ko(input logic [127:0] k);
`ifdef ADDROUNDKEY_EN
    return state_in ^ k;
`else
    return k;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic e_en, input logic e_rd, input logic [15:0] e_addr,
                     input logic e_vld, input logic [127:0] e_key, input logic [3:0] e_rnd,
                     input logic e_busy, input logic e_sd);
    total++;
    n_en += int'(key_exp_enable);
    n_sd += int'(schedule_done);
    if (key_exp_enable !== e_en || sram_read !== e_rd || sram_addr !== e_addr ||
        key_out_valid !== e_vld || key_out !== e_key || round_num !== e_rnd ||
        busy !== e_busy || schedule_done !== e_sd) begin
      bad++;
      $display("FAIL %s t=%0t got/exp en=%b/%b rd=%b/%b addr=%h/%h vld=%b/%b key=%h/%h rnd=%0d/%0d busy=%b/%b sdone=%b/%b",
               nm, $time, key_exp_enable, e_en, sram_read, e_rd, sram_addr, e_addr, key_out_valid, e_vld,
               key_out, e_key, round_num, e_rnd, busy, e_busy, schedule_done, e_sd);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic noise(input bit rnd, input bit allow_done);
    if (rnd) begin
      key_out_ready  = 1'($urandom_range(0, 1));
      expansion_done = allow_done && ($urandom_range(0, 2) == 0);
      start          = ($urandom_range(0, 3) == 0);
    end else begin
      key_out_ready  = 1'b0;
      expansion_done = 1'b0;
      start          = 1'b0;
    end
  endtask

  // Expected timing: read0 +1, capture +2, valid +3; after a handshake the enable
  // follows at once, expander replies after s_dly, read at done+1+HOLD, valid 2 later.
  task automatic run_sched(input bit rnd);
    n_en = 0;
    n_sd = 0;
    mem_key0 = s_key[0];
    start = 1'b1;
    expansion_done = 1'b0;
    key_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    step; chk("read0", 0, 1, A0, 0, 128'd0, 4'd0, 1, 0); noise(rnd, 1);
    step; chk("capt0", 0, 0, 16'd0, 0, 128'd0, 4'd0, 1, 0); noise(rnd, 1);
    for (int r = 0; r <= NR; r++) begin
      for (int s = 0; s <= int'(s_stl[r]); s++) begin
        step; chk("present", 0, 0, 16'd0, 1, exp_ko(s_key[r]), s_rnd[r], 1, 0);
        noise(rnd, 1);
        key_out_ready = (s == int'(s_stl[r]));
      end
      if (r == NR) begin
        step; chk("done", 0, 0, 16'd0, 0, 128'd0, 4'(NR), 1, 1); noise(rnd, 1);
        step; chk("idle_after_done", 0, 0, 16'd0, 0, 128'd0, 4'(NR), 0, 0);
        start = 1'b0; expansion_done = 1'b0; key_out_ready = 1'b0;
      end else begin
        step; chk("kick", 1, 0, 16'd0, 0, 128'd0, 4'(r + 1), 1, 0); noise(rnd, 1);
        for (int w = 1; w <= int'(s_dly[r + 1]); w++) begin
          step; chk("wait_exp", 0, 0, 16'd0, 0, 128'd0, 4'(r + 1), 1, 0);
          noise(rnd, 0);
          if (w == int'(s_dly[r + 1])) begin
            mem_keyn = s_key[r + 1];
            expansion_done = 1'b1;
          end
        end
        for (int h = 0; h < HOLD; h++) begin
          step; chk("holdoff", 0, 0, 16'd0, 0, 128'd0, 4'(r + 1), 1, 0); noise(rnd, 1);
        end
        step; chk("readk", 0, 1, AN, 0, 128'd0, 4'(r + 1), 1, 0); noise(rnd, 1);
        step; chk("captk", 0, 0, 16'd0, 0, 128'd0, 4'(r + 1), 1, 0); noise(rnd, 1);
      end
    end
    chk_int("enable_pulses", n_en, NR);
    chk_int("schedule_done_pulses", n_sd, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 20, 4'd0};
    tbl[1]  = '{128'ha0fafe1788542cb123a339392a6c7605, 1, 0, 4'd1};
    tbl[2]  = '{128'hf2c295f27a96b9435935807a7359f67f, 3, 1, 4'd2};
    tbl[3]  = '{128'h3d80477d4716fe3e1e237e446d7a883b, 2, 0, 4'd3};
    tbl[4]  = '{128'hef44a541a8525b7fb671253bdb0bad00, 8, 3, 4'd4};
    tbl[5]  = '{128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1, 0, 4'd5};
    tbl[6]  = '{128'h6d88a37a110b3efddbf98641ca0093fd, 5, 2, 4'd6};
    tbl[7]  = '{128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1, 0, 4'd7};
    tbl[8]  = '{128'head27321b58dbad2312bf5607f8d292f, 4, 1, 4'd8};
    tbl[9]  = '{128'hac7766f319fadc2128d12941575c006e, 2, 0, 4'd9};
    tbl[10] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 6, 4, 4'd10};

    n_rst = 1'b0; start = 1'b0; expansion_done = 1'b0; key_out_ready = 1'b0;
    state_in = 128'h3243f6a8885a308d313198a2e0370734;
    mem_key0 = 128'd0; mem_keyn = 128'd0;
    n_en = 0; n_sd = 0;
    #2;
    chk("reset_state", 0, 0, 16'd0, 0, 128'd0, 4'd0, 0, 0);
    @(negedge clk) n_rst = 1'b1;
    step; chk("idle_out_of_reset", 0, 0, 16'd0, 0, 128'd0, 4'd0, 0, 0);

    // round 0 fetch, one handshake, then async reset in the middle of WAIT_EXP
    mem_key0 = tbl[0].key;
    start = 1'b1;
    step; chk("r0_read", 0, 1, A0, 0, 128'd0, 4'd0, 1, 0); start = 1'b0;
    step; chk("r0_capt", 0, 0, 16'd0, 0, 128'd0, 4'd0, 1, 0);
    step; chk("r0_valid", 0, 0, 16'd0, 1, exp_ko(tbl[0].key), 4'd0, 1, 0);
`ifdef ADDROUNDKEY_EN
    chk128("addroundkey_vector", key_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
`else
    chk128("round0_key_vector", key_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif
    key_out_ready = 1'b1;
    step; chk("r1_kick", 1, 0, 16'd0, 0, 128'd0, 4'd1, 1, 0); key_out_ready = 1'b0;
    step; chk("r1_wait_a", 0, 0, 16'd0, 0, 128'd0, 4'd1, 1, 0);
    step; chk("r1_wait_b", 0, 0, 16'd0, 0, 128'd0, 4'd1, 1, 0);
    #2 n_rst = 1'b0;
    #1 chk("async_reset", 0, 0, 16'd0, 0, 128'd0, 4'd0, 0, 0);
    step; chk("held_in_reset", 0, 0, 16'd0, 0, 128'd0, 4'd0, 0, 0);
    @(negedge clk) n_rst = 1'b1;
    step; chk("idle_after_reset", 0, 0, 16'd0, 0, 128'd0, 4'd0, 0, 0);

    for (int i = 0; i <= NR; i++) begin
      s_key[i] = tbl[i].key;
      s_dly[i] = tbl[i].dly;
      s_stl[i] = tbl[i].stall;
      s_rnd[i] = tbl[i].exp_round;
    end
    run_sched(1'b0);

    for (int k = 0; k < 4; k++) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i <= NR; i++) begin
        s_key[i] = {$urandom, $urandom, $urandom, $urandom};
        s_dly[i] = $urandom_range(1, 8);
        s_stl[i] = $urandom_range(0, 4);
        s_rnd[i] = 4'(i);
      end
      run_sched(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
